// File: rtl/adc_capture_if.sv
// Sample-in / readout bundle between the ADC front end, the snapshot buffer and the host reader.
// No logic of its own; timing is defined by the modules on either side.
// master drives samples and read requests, slave returns read data.
interface adc_capture_if;
    logic [15:0] din;
    logic        din_valid;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_last;

    modport master (
        output din, din_valid, rd_en,
        input  rd_data, rd_valid, rd_last
    );

    modport slave (
        input  din, din_valid, rd_en,
        output rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/adc_capture.sv
// Triggered snapshot buffer: stores DEPTH samples around a level crossing, then reads them out oldest first.
// Capture writes on the same edge that samples din_valid; a read returns data 2 cycles after rd_en.
// Samples cannot be stalled (dropped once in READ); one read is outstanding at a time, extra rd_en is ignored.
module adc_capture #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clkin,
    input  logic                  rst,
    adc_capture_if.slave          bus,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [DEPTH_LOG2-1:0] pretrig,
    input  logic [15:0]           level,
    input  logic                  falling,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT, S_POST, S_READ} state_t;

    state_t state, state_nxt;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, fill_cnt, post_cnt, trig_ptr, pretrig_q, rd_cnt, rd_addr, rd_ptr;
    logic signed [15:0]    prev, level_q, din_s;
    logic                  prev_ok, falling_q, force_pend, trig_q;
    logic                  rd_req, rd_req_last, rd_fin;
    logic                  capturing, wr_en, edge_hit, trig_fire, rd_accept;
    logic [DEPTH_LOG2-1:0] post_init;

    assign din_s     = bus.din;
    assign capturing = (state == S_PREFILL) || (state == S_WAIT) || (state == S_POST);
    assign wr_en     = capturing && bus.din_valid && !abort;
    assign edge_hit  = prev_ok && (falling_q ? (prev > level_q && din_s <= level_q)
                                             : (prev < level_q && din_s >= level_q));
    assign trig_fire = (state == S_WAIT) && bus.din_valid && !abort
                       && (edge_hit || force_trig || force_pend);
    // Samples remaining after the trigger sample: DEPTH - 1 - pretrig, i.e. the bitwise complement.
    assign post_init = ~pretrig_q;
    // Oldest sample of the window sits pretrig slots before the trigger sample.
    assign rd_ptr    = trig_ptr - pretrig_q + rd_cnt;
    assign rd_accept = (state == S_READ) && bus.rd_en && !rd_req && !rd_fin;

    assign busy      = capturing;
    assign done      = (state == S_READ);
    assign triggered = trig_q;

    // State register.
    always_ff @(posedge clkin) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = (pretrig == '0) ? S_WAIT : S_PREFILL;
            S_PREFILL: if (wr_en && (fill_cnt + PTR_ONE) == pretrig_q) state_nxt = S_WAIT;
            S_WAIT:    if (trig_fire) state_nxt = (post_init == '0) ? S_READ : S_POST;
            S_POST:    if (wr_en && post_cnt == PTR_ONE) state_nxt = S_READ;
            S_READ:    if (bus.rd_valid && bus.rd_last) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Circular sample store; contents survive abort and reset.
    always_ff @(posedge clkin) begin
        if (wr_en) mem[wr_ptr] <= bus.din;
    end

    // Capture bookkeeping: arm latching, write pointer, edge history, trigger and post count.
    always_ff @(posedge clkin) begin
        if (rst) begin
            pretrig_q  <= '0;
            level_q    <= '0;
            falling_q  <= 1'b0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            trig_ptr   <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
            force_pend <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && arm && !abort) begin
                pretrig_q <= pretrig;
                level_q   <= level;
                falling_q <= falling;
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                prev_ok   <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fill_cnt <= fill_cnt + PTR_ONE;
                prev     <= din_s;
                prev_ok  <= 1'b1;
            end
            if (state == S_POST && wr_en) post_cnt <= post_cnt - PTR_ONE;
            if (trig_fire) begin
                trig_ptr <= wr_ptr;
                post_cnt <= post_init;
                trig_q   <= 1'b1;
            end
            // A force seen between samples waits for the next sample, but only while in WAIT.
            if (state != S_WAIT || abort || trig_fire) force_pend <= 1'b0;
            else if (force_trig && !bus.din_valid)     force_pend <= 1'b1;
            if (state_nxt == S_IDLE) trig_q <= 1'b0;
        end
    end

    // Readout pipeline: registered address, then registered RAM output.
    always_ff @(posedge clkin) begin
        if (rst) begin
            rd_cnt       <= '0;
            rd_fin       <= 1'b0;
            rd_addr      <= '0;
            rd_req       <= 1'b0;
            rd_req_last  <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
        end else begin
            if (state == S_IDLE && arm && !abort) begin
                rd_cnt <= '0;
                rd_fin <= 1'b0;
            end
            if (rd_accept) begin
                rd_addr <= rd_ptr;
                rd_cnt  <= rd_cnt + PTR_ONE;
                if (&rd_cnt) rd_fin <= 1'b1;
            end
            rd_req       <= rd_accept && !abort;
            rd_req_last  <= rd_accept && !abort && (&rd_cnt);
            bus.rd_valid <= rd_req && !abort;
            bus.rd_last  <= rd_req_last && !abort;
            if (rd_req) bus.rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: directed and random captures against a sample-history model, scoreboarded readout.
// Expected windows are pushed when a capture completes; a monitor pops on every rd_valid.
// Reads are issued back-to-back or with random gaps to exercise the single-outstanding rule.
module tb_adc_capture;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clkin = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0, abort = 1'b0, force_trig = 1'b0, falling = 1'b0;
    logic [DL-1:0] pretrig = '0;
    logic [15:0]   level = '0;
    logic          busy, triggered, done;

    adc_capture_if bus ();

    adc_capture #(.DEPTH_LOG2(DL)) dut (
        .clkin(clkin), .rst(rst), .bus(bus), .arm(arm), .abort(abort),
        .force_trig(force_trig), .pretrig(pretrig), .level(level), .falling(falling),
        .busy(busy), .triggered(triggered), .done(done)
    );

    always #5 clkin = ~clkin;

    int n_vec = 0, n_err = 0, rcv_cnt = 0;

    // Reference model: every stored sample since arm, the index of the trigger sample, pending force.
    int                 m_pt;
    logic signed [15:0] m_lv;
    logic               m_fl;
    logic signed [15:0] hist[$];
    int                 trig_idx;
    bit                 fpend;
    logic [16:0]        exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit complete();
        return (trig_idx >= 0) && (hist.size() == trig_idx + DEPTH - m_pt);
    endfunction

    task automatic start(input int pt, input int lv, input logic fl);
        pretrig = DL'(pt); level = 16'(lv); falling = fl; arm = 1'b1;
        @(negedge clkin);
        arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
        m_pt = pt; m_lv = 16'(lv); m_fl = fl;
        hist.delete(); trig_idx = -1; fpend = 0;
    endtask

    // One input cycle: model decides whether this sample is the trigger, then DUT flags are compared.
    task automatic step(input logic v, input logic signed [15:0] d, input logic f);
        int c;
        bit in_wait, hit;
        bus.din_valid = v; bus.din = d; force_trig = f;
        c = hist.size();
        in_wait = (trig_idx < 0) && (c >= m_pt);
        hit = 0;
        if (v && in_wait) begin
            if (f || fpend) hit = 1;
            if (c > 0) begin
                if (!m_fl && hist[c-1] < m_lv && d >= m_lv) hit = 1;
                if (m_fl && hist[c-1] > m_lv && d <= m_lv) hit = 1;
            end
        end
        if (!v && in_wait && f) fpend = 1;
        if (v) hist.push_back(d);
        if (hit) trig_idx = c;
        @(negedge clkin);
        bus.din_valid = 1'b0; force_trig = 1'b0;
        chk("done", 32'(done), 32'(complete()));
        chk("triggered", 32'(triggered), 32'(trig_idx >= 0));
        chk("busy", 32'(busy), 32'(!complete()));
    endtask

    task automatic readout(input bit cont);
        int s, cyc;
        s = rcv_cnt; cyc = 0;
        while (rcv_cnt - s < DEPTH && cyc < 400) begin
            bus.rd_en = cont ? 1'b1 : ($urandom_range(0, 2) == 0);
            @(negedge clkin);
            cyc++;
        end
        bus.rd_en = 1'b0;
        chk("read_count", 32'(rcv_cnt - s), 32'(DEPTH));
        if (cont) chk("read_cycles", 32'(cyc), 32'(2 * DEPTH));
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clkin);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_triggered", 32'(triggered), 32'd0);
    endtask

    task automatic finish_capture(input bit cont);
        chk("capture_complete", 32'(complete()), 32'd1);
        if (complete()) begin
            for (int i = 0; i < DEPTH; i++)
                exp_q.push_back({(i == DEPTH - 1), hist[trig_idx - m_pt + i]});
            readout(cont);
        end else begin
            abort = 1'b1;
            @(negedge clkin);
            abort = 1'b0;
        end
    endtask

    // Scoreboard monitor: every returned sample must match the head of the expected window.
    initial begin : monitor
        logic [16:0] e;
        forever begin
            @(posedge clkin);
            #1;
            if (bus.rd_valid === 1'b1) begin
                rcv_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd_unexpected: got data %0h, expected no response", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_sample", {15'b0, bus.rd_last, bus.rd_data}, {15'b0, e});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.din = '0; bus.din_valid = 1'b0; bus.rd_en = 1'b0;
        repeat (3) @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);

        // Rising ramp through level 0 with four pre-trigger samples.
        start(4, 0, 1'b0);
        for (int i = -8; i <= 20 && !complete(); i++) step(1'b1, 16'(i), 1'b0);
        finish_capture(1'b1);

        // Falling crossing on an alternating waveform, no pre-trigger samples.
        start(0, 0, 1'b1);
        for (int i = 0; i < 40 && !complete(); i++) step(1'b1, 16'((i % 2 == 0) ? 100 : -100), 1'b0);
        finish_capture(1'b0);

        // Forced trigger on the last window slot; a force during prefill must be forgotten.
        start(15, 32767, 1'b0);
        for (int i = 0; i < 15; i++) begin
            if (i == 3) step(1'b0, 16'd0, 1'b1);
            step(1'b1, 16'($urandom_range(0, 100)), 1'b0);
        end
        step(1'b1, 16'h1234, 1'b1);
        finish_capture(1'b1);

        // Long wait wrapping the buffer several times before a step crosses the level.
        start(5, 1000, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'd2000, 1'b0);
        for (int i = 0; i < 40 && !complete(); i++) step(1'b1, 16'($urandom_range(0, 3000)), 1'b0);
        finish_capture(1'b0);

        // Gapped input; idle cycles carry a value that would trigger if sampled.
        start(3, 20, 1'b0);
        k = 0;
        for (int c = 0; c < 100 && !complete(); c++) begin
            if (c % 2 == 0) begin
                step(1'b1, 16'(5 * k), 1'b0);
                k++;
            end else begin
                step(1'b0, 16'h7fff, 1'b0);
            end
        end
        finish_capture(1'b1);

        // Abort during POST, arm with abort, then a clean falling capture.
        start(8, 0, 1'b0);
        for (int i = -10; i <= 20 && (trig_idx < 0 || hist.size() < trig_idx + 3); i++)
            step(1'b1, 16'(i), 1'b0);
        abort = 1'b1;
        @(negedge clkin);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_triggered", 32'(triggered), 32'd0);
        arm = 1'b1; abort = 1'b1;
        @(negedge clkin);
        arm = 1'b0; abort = 1'b0;
        chk("arm_with_abort_busy", 32'(busy), 32'd0);
        @(negedge clkin);
        chk("arm_with_abort_busy_late", 32'(busy), 32'd0);
        start(2, -5, 1'b1);
        for (int i = 10; i >= -40 && !complete(); i--) step(1'b1, 16'(i), 1'b0);
        finish_capture(1'b0);

        // Reset while a read is in flight squashes the response.
        start(4, 0, 1'b0);
        for (int i = -8; i <= 20 && !complete(); i++) step(1'b1, 16'(i), 1'b0);
        bus.rd_en = 1'b1;
        @(negedge clkin);
        bus.rd_en = 1'b0; rst = 1'b1;
        @(negedge clkin);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_read_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("rst_read_done", 32'(done), 32'd0);
            @(negedge clkin);
        end

        // Random captures: random settings, gaps and occasional forces.
        for (int r = 0; r < 4; r++) begin
            start($urandom_range(0, 15), int'($urandom_range(0, 40)) - 20, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 400 && !complete(); c++)
                step($urandom_range(0, 3) != 0, 16'(int'($urandom_range(0, 100)) - 50),
                     $urandom_range(0, 39) == 0);
            finish_capture(r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_capture.md
# adc_capture

Triggered snapshot buffer for the 16-bit ADC sample stream. It sits directly downstream of the LVDS/DDR ADC capture stage and stores a window of DEPTH samples in block RAM around a level-crossing trigger. The window includes a programmable pre-trigger portion. Host logic then reads the stored window out in chronological order through a simple request/response port.

## Interface
Parameters:
- DEPTH_LOG2, 10: buffer depth is DEPTH = 2**DEPTH_LOG2 samples; legal range 4..14.

Ports:
- clkin, in, 1: sample/system clock; everything is synchronous to its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- din, in, 16: ADC sample, signed two's complement, synchronous to clkin.
- din_valid, in, 1: din holds a new sample this cycle.
- arm, in, 1: one-cycle pulse that starts a capture; honoured only in IDLE.
- abort, in, 1: one-cycle pulse that returns the block to IDLE from any state.
- force, in, 1: manual trigger, honoured only in WAIT_TRIG.
- pretrig, in, DEPTH_LOG2: number of samples stored before the trigger sample; latched on accepted arm.
- level, in, 16: signed trigger threshold; latched on accepted arm.
- falling, in, 1: 0 = trigger on rising crossing, 1 = trigger on falling crossing; latched on accepted arm.
- busy, out, 1: high in PREFILL, WAIT_TRIG and POST.
- triggered, out, 1: high from the trigger sample until the block returns to IDLE.
- done, out, 1: high in READ.
- rd_en, in, 1: request the next stored sample; ignored outside READ and while a request is pending.
- rd_data, out, 16: read sample.
- rd_valid, out, 1: rd_data is valid; one-cycle pulse.
- rd_last, out, 1: qualifies rd_valid for the final (DEPTH-th) sample.

## Operation
- The state machine has five states: IDLE, PREFILL, WAIT_TRIG, POST and READ.
- **IDLE.** On arm (with no abort), the block latches pretrig, level and falling, clears wr_ptr, fill count and prev_ok, then goes to PREFILL. If the latched pretrig is 0 it goes directly to WAIT_TRIG.
- **Write rule (PREFILL, WAIT_TRIG, POST).** Each din_valid writes din to RAM[wr_ptr]. wr_ptr then increments modulo DEPTH, so wrap-around is silent. prev is set to din and prev_ok to 1.
- **PREFILL.** The block counts written samples. When the count reaches pretrig (on the cycle of the pretrig-th write), it moves to WAIT_TRIG.
- **WAIT_TRIG.** Every din_valid sample is written circularly. A trigger fires on the current sample when either condition holds:
  - prev_ok is set and the latched edge condition is met:
    - rising: prev < level and din >= level (signed compare);
    - falling: prev > level and din <= level (signed compare).
  - force is asserted together with din_valid. force without din_valid is held pending until the next din_valid.
- **On trigger.**
  - trig_ptr takes the address the trigger sample is written to.
  - The post counter loads DEPTH - pretrig - 1.
  - triggered is set and the state moves to POST, or straight to READ if the post count is 0.
- **POST.** Each written sample decrements the post counter. The write that takes it to 0 is the last write, and the state moves to READ. The trigger sample is stored at window index pretrig.
- **READ.** rd_ptr starts at (trig_ptr - pretrig) mod DEPTH. Each accepted rd_en reads RAM[rd_ptr], increments rd_ptr modulo DEPTH and increments the read count. When the DEPTH-th sample is returned with rd_last, the state goes to IDLE and triggered clears. Samples arriving on din during READ are discarded.
- **Abort.** abort in any state returns to IDLE; RAM contents are left unchanged.
  - abort on the same cycle as arm: abort wins.
  - abort on the same cycle as a trigger: abort wins.
- **Other inputs.** arm outside IDLE is ignored. force outside WAIT_TRIG is ignored and does not stay pending.

## Timing
- **Reset values.** busy=0, triggered=0, done=0, rd_valid=0, rd_last=0, rd_data=0, state=IDLE, all pointers and counters 0. Reset mid-capture or mid-readout behaves the same as abort.
- **Input to state change.** An accepted arm makes busy=1 on the next cycle. The write of a sample and its trigger evaluation occur on the same edge that samples din_valid.
- **Flags after state changes.** triggered rises the cycle after the trigger sample edge. done rises the cycle after the final post-trigger write.
- **Read latency.** rd_data/rd_valid arrive exactly 2 cycles after rd_en (registered address, then registered RAM output). One request may be outstanding at a time.
- **Back-to-back reads.** rd_en asserted every cycle yields one sample every 2 cycles.
- **Return to IDLE.** IDLE is entered on the cycle after rd_valid&rd_last. An arm on that following cycle is accepted.

## Test plan
- DEPTH_LOG2=4, pretrig=4, level=0, rising edge, ramp din = -8,-7,…,+20 with din_valid continuous. Trigger on the sample 0. Readout gives -4,-3,…,+11, rd_last on +11, and 16 rd_valid pulses.
- Same setup but pretrig=0 and falling edge, din alternating +100/-100. Trigger on the first -100 that follows a +100. Readout starts with -100, alternates, and contains 16 samples.
- pretrig=15 with force pulsed with din_valid on din=0x1234. Readout index 15 is 0x1234 and is flagged rd_last. POST is skipped and done rises on the next cycle.
- Long WAIT_TRIG with wrap-around: 50 samples of counter value 0..49 with level=1000, then step to 2000. The window holds the pretrig samples preceding 2000 in order, across the wrap.
- din_valid toggling 1-0-1: the gaps store nothing and window contents equal the valid samples only. A sample equal to level following a sample below level triggers.
- abort issued in POST, then arm issued together with abort, then a clean arm. Each abort gives busy=0 and done=0, the simultaneous arm is ignored, and the clean arm captures normally. A rst pulse during READ clears rd_valid and done.
